// File: rtl/spi_adc_pkg.sv
// ============================================================================
// Module : spi_adc_pkg
// Brief  : Shared types, edge-selection constants and configuration helpers
//          for the SPI ADC multiplexing slave.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package spi_adc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        CONV = 3'd2,
        DATA = 3'd3,
        HOLD = 3'd4
    } state_t;

    // Mode number is {CPOL, CPHA}
    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } spi_mode_t;

    localparam logic c_EDGE_LEAD  = 1'b0;
    localparam logic c_EDGE_TRAIL = 1'b1;

    function automatic spi_mode_t mode_of(input int cpol, input int cpha);
        return spi_mode_t'({(cpol != 0), (cpha != 0)});
    endfunction

    function automatic logic sample_edge_sel(input spi_mode_t mode);
        return mode[0] ? c_EDGE_TRAIL : c_EDGE_LEAD;
    endfunction

    // Index of the first data bit on the wire (L)
    function automatic int unsigned latch_point(input int unsigned frame_w,
                                                input int unsigned data_w);
        return frame_w - data_w;
    endfunction

    // Ordinal of the shift edge that opens bit L, counted among edges of its kind
    function automatic int unsigned latch_edge_idx(input int unsigned frame_w,
                                                   input int unsigned data_w,
                                                   input int unsigned cpha);
        return latch_point(frame_w, data_w) + ((cpha != 0) ? 1 : 0);
    endfunction

    function automatic logic cfg_ok(input int unsigned frame_w,
                                    input int unsigned data_w,
                                    input int unsigned ch_w);
        return (ch_w >= 1) && (frame_w >= data_w + ch_w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_adc_mux_slave_if.sv
// ============================================================================
// Module : spi_adc_mux_slave_if
// Brief  : SPI pin and ADC macro signal bundle for the ADC multiplexing slave.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface spi_adc_mux_slave_if #(
    parameter int DATA_W = 12,
    parameter int CH_W   = 3
);
    logic              ss;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [CH_W-1:0]   adc_ch;
    logic              adc_soc;
    logic              adc_eoc;
    logic [DATA_W-1:0] adc_data;
    logic              frame_done;
    logic              adc_late;

    modport slave (
        input  ss, sclk, mosi, adc_eoc, adc_data,
        output miso, miso_oe, adc_ch, adc_soc, frame_done, adc_late
    );

    modport master (
        output ss, sclk, mosi, adc_eoc, adc_data,
        input  miso, miso_oe, adc_ch, adc_soc, frame_done, adc_late
    );
endinterface

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module : spi_sync_edge
// Brief  : Multi-flop synchroniser with an edge flop; reports level, rise, fall.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  wire  clk,
    input  wire  xres,
    input  wire  i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edge;

    if (SYNC_STAGES < 2) begin : g_stage_check
        $error("spi_sync_edge: SYNC_STAGES must be at least 2");
    end

    // Reset to the idle level so that leaving reset creates no false edge
    always_ff @(posedge clk) begin
        if (xres) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_edge <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            r_edge <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_edge;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_edge;

endmodule

`default_nettype wire

// File: rtl/spi_adc_mux_slave.sv
// ============================================================================
// Module : spi_adc_mux_slave
// Brief  : SPI slave that selects an ADC channel, starts one conversion and
//          returns the result MSB first; all four SPI modes, oversampled.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_adc_mux_slave
    import spi_adc_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int FRAME_W     = 16,
    parameter int CH_W        = 3,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input wire                 clk,
    input wire                 xres,
    spi_adc_mux_slave_if.slave bus
);

    localparam int                 c_CNT_W      = $clog2(FRAME_W + 1);
    localparam logic [c_CNT_W-1:0] c_CH_LAST    = c_CNT_W'(CH_W - 1);
    localparam logic [c_CNT_W-1:0] c_LATCH      = c_CNT_W'(latch_point(FRAME_W, DATA_W));
    localparam logic [c_CNT_W-1:0] c_FRAME_LAST = c_CNT_W'(FRAME_W - 1);
    localparam logic [c_CNT_W-1:0] c_FRAME_FULL = c_CNT_W'(FRAME_W);
    localparam spi_mode_t          c_MODE       = mode_of(CPOL, CPHA);
    localparam logic               c_SAMPLE_SEL = sample_edge_sel(c_MODE);

    if (!cfg_ok(FRAME_W, DATA_W, CH_W)) begin : g_cfg_check
        $error("spi_adc_mux_slave: FRAME_W must be >= DATA_W + CH_W + 1");
    end

    logic w_ss_lvl, w_ss_rise, w_ss_fall;
    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
    logic w_unused_sync;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .xres(xres), .i_din(bus.ss),
        .o_level(w_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL != 0)) u_sync_sclk (
        .clk(clk), .xres(xres), .i_din(bus.sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .xres(xres), .i_din(bus.mosi),
        .o_level(w_mosi_lvl), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused_sync = &{1'b0, w_sclk_lvl, w_mosi_rise, w_mosi_fall};

    logic w_lead, w_trail, w_sample, w_shift;

    assign w_lead   = (CPOL != 0) ? w_sclk_fall : w_sclk_rise;
    assign w_trail  = (CPOL != 0) ? w_sclk_rise : w_sclk_fall;
    assign w_sample = (c_SAMPLE_SEL == c_EDGE_LEAD) ? w_lead  : w_trail;
    assign w_shift  = (c_SAMPLE_SEL == c_EDGE_LEAD) ? w_trail : w_lead;

    state_t              r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [CH_W-1:0]     r_ch_sh;
    logic [CH_W-1:0]     r_ch;
    logic [DATA_W-1:0]   r_sr;
    logic                r_conv_done;
    logic                r_soc;
    logic                r_frame_done;
    logic                r_late;

    logic                w_ch_done;
    logic                w_latch;
    logic                w_last;
    logic                w_data_ok;
    logic                w_active;
    logic [CH_W-1:0]     w_ch_in;

    assign w_ch_in   = CH_W'({r_ch_sh, w_mosi_lvl});
    assign w_data_ok = r_conv_done | bus.adc_eoc;
    assign w_active  = (r_state == CMD) || (r_state == CONV) || (r_state == DATA);

    always_ff @(posedge clk) begin
        if (xres) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A final sample edge coinciding with ss rise still completes the frame
    always_comb begin
        w_state_nxt = r_state;
        w_ch_done   = 1'b0;
        w_latch     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_fall) w_state_nxt = CMD;
            end
            CMD: begin
                if (w_ss_rise) begin
                    w_state_nxt = IDLE;
                end else if (w_sample && (r_cnt == c_CH_LAST)) begin
                    w_ch_done   = 1'b1;
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                if (w_ss_rise) begin
                    w_state_nxt = IDLE;
                end else if (w_shift && (r_cnt == c_LATCH)) begin
                    w_latch     = 1'b1;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_sample && (r_cnt == c_FRAME_LAST)) begin
                    w_last      = 1'b1;
                    w_state_nxt = w_ss_rise ? IDLE : HOLD;
                end else if (w_ss_rise) begin
                    w_state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (w_ss_rise) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (xres) begin
            r_cnt        <= '0;
            r_ch_sh      <= '0;
            r_ch         <= '0;
            r_sr         <= '0;
            r_conv_done  <= 1'b0;
            r_soc        <= 1'b0;
            r_frame_done <= 1'b0;
            r_late       <= 1'b0;
        end else begin
            r_soc        <= w_ch_done;
            r_frame_done <= w_last;
            r_late       <= w_latch & ~w_data_ok;

            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if (w_active && w_sample && (r_cnt != c_FRAME_FULL)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == IDLE) begin
                r_ch_sh <= '0;
            end else if ((r_state == CMD) && w_sample) begin
                r_ch_sh <= w_ch_in;
            end

            if (w_ch_done) begin
                r_ch <= w_ch_in;
            end

            // Conversions outside CONV (including an aborted frame's) are ignored
            if (w_ch_done) begin
                r_conv_done <= 1'b0;
            end else if ((r_state == CONV) && bus.adc_eoc) begin
                r_conv_done <= 1'b1;
            end

            if (r_state == IDLE) begin
                r_sr <= '0;
            end else if (w_latch) begin
                r_sr <= w_data_ok ? bus.adc_data : '0;
            end else if ((r_state == DATA) && w_shift) begin
                r_sr <= {r_sr[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign bus.miso       = (r_state == DATA) ? r_sr[DATA_W-1] : 1'b0;
    assign bus.miso_oe    = ~w_ss_lvl;
    assign bus.adc_ch     = r_ch;
    assign bus.adc_soc    = r_soc;
    assign bus.frame_done = r_frame_done;
    assign bus.adc_late   = r_late;

endmodule

`default_nettype wire

// File: tb/tb_spi_adc_mux_slave.sv
// ============================================================================
// Module : tb_spi_adc_mux_slave
// Brief  : Bench for spi_adc_mux_slave: four mode instances plus a wide build,
//          an SPI master model per instance and an ADC responder.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_adc_mux_slave;
    import spi_adc_pkg::*;

    localparam int c_NDUT = 5;
    localparam int c_HALF = 8;

    logic clk;
    logic xres;

    logic [c_NDUT-1:0]       ss_d, sclk_d, mosi_d, eoc_d;
    logic [c_NDUT-1:0][15:0] data_d;
    logic [c_NDUT-1:0]       miso_w, oe_w, soc_w, fd_w, late_w;
    logic [c_NDUT-1:0][3:0]  ch_w;

    int   cpol_t [c_NDUT] = '{0, 0, 1, 1, 0};
    int   cpha_t [c_NDUT] = '{0, 1, 0, 1, 0};
    int   chw_t  [c_NDUT] = '{3, 3, 3, 3, 4};

    int          n_fd   [c_NDUT];
    int          n_soc  [c_NDUT];
    int          n_late [c_NDUT];
    int          wait_c [c_NDUT];
    bit          pend   [c_NDUT];
    int          eoc_delay [c_NDUT];
    bit          eoc_en    [c_NDUT];
    logic [15:0] adc_val   [c_NDUT];

    int n_chk;
    int n_fail;

    typedef struct {
        int          d;
        logic [31:0] word;
        logic [3:0]  ch;
        int          late;
    } exp_t;

    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_m
        spi_adc_mux_slave_if #(.DATA_W(12), .CH_W(3)) bus ();
        assign bus.ss       = ss_d[gi];
        assign bus.sclk     = sclk_d[gi];
        assign bus.mosi     = mosi_d[gi];
        assign bus.adc_eoc  = eoc_d[gi];
        assign bus.adc_data = data_d[gi][11:0];

        spi_adc_mux_slave #(
            .DATA_W(12), .FRAME_W(16), .CH_W(3),
            .CPOL(gi / 2), .CPHA(gi % 2), .SYNC_STAGES(2)
        ) u_dut (
            .clk(clk), .xres(xres), .bus(bus.slave)
        );

        assign miso_w[gi] = bus.miso;
        assign oe_w[gi]   = bus.miso_oe;
        assign soc_w[gi]  = bus.adc_soc;
        assign fd_w[gi]   = bus.frame_done;
        assign late_w[gi] = bus.adc_late;
        assign ch_w[gi]   = {1'b0, bus.adc_ch};
    end

    spi_adc_mux_slave_if #(.DATA_W(16), .CH_W(4)) bus_w ();
    assign bus_w.ss       = ss_d[4];
    assign bus_w.sclk     = sclk_d[4];
    assign bus_w.mosi     = mosi_d[4];
    assign bus_w.adc_eoc  = eoc_d[4];
    assign bus_w.adc_data = data_d[4];

    spi_adc_mux_slave #(
        .DATA_W(16), .FRAME_W(24), .CH_W(4), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)
    ) u_dut_w (
        .clk(clk), .xres(xres), .bus(bus_w.slave)
    );

    assign miso_w[4] = bus_w.miso;
    assign oe_w[4]   = bus_w.miso_oe;
    assign soc_w[4]  = bus_w.adc_soc;
    assign fd_w[4]   = bus_w.frame_done;
    assign late_w[4] = bus_w.adc_late;
    assign ch_w[4]   = bus_w.adc_ch;

    // ADC responder and event counters for every instance
    always @(posedge clk) begin
        for (int k = 0; k < c_NDUT; k++) begin
            eoc_d[k] <= 1'b0;
            if (fd_w[k])   n_fd[k]   <= n_fd[k] + 1;
            if (late_w[k]) n_late[k] <= n_late[k] + 1;
            if (soc_w[k]) begin
                n_soc[k]  <= n_soc[k] + 1;
                wait_c[k] <= eoc_delay[k];
                pend[k]   <= eoc_en[k];
            end else if (pend[k]) begin
                if (wait_c[k] <= 1) begin
                    eoc_d[k]  <= 1'b1;
                    data_d[k] <= adc_val[k];
                    pend[k]   <= 1'b0;
                end else begin
                    wait_c[k] <= wait_c[k] - 1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master model: channel MSB first, then zeros; captures miso into word
    task automatic spi_frame(input int d, input logic [3:0] ch, input int nbits,
                             input bit keep_ss, output logic [31:0] word);
        logic lvl;
        lvl  = (cpol_t[d] != 0);
        word = '0;
        ss_d[d] = 1'b0;
        wait_clks(c_HALF);
        for (int i = 0; i < nbits; i++) begin
            if (cpha_t[d] == 0) begin
                mosi_d[d] = (i < chw_t[d]) ? ch[chw_t[d]-1-i] : 1'b0;
                wait_clks(c_HALF);
                sclk_d[d] = ~lvl;
                word = {word[30:0], miso_w[d]};
                wait_clks(c_HALF);
                sclk_d[d] = lvl;
            end else begin
                sclk_d[d] = ~lvl;
                mosi_d[d] = (i < chw_t[d]) ? ch[chw_t[d]-1-i] : 1'b0;
                wait_clks(c_HALF);
                sclk_d[d] = lvl;
                word = {word[30:0], miso_w[d]};
                wait_clks(c_HALF);
            end
        end
        wait_clks(c_HALF);
        if (!keep_ss) ss_d[d] = 1'b1;
    endtask

    task automatic run_frame(input int d, input logic [3:0] ch, input logic [15:0] val,
                             input int nbits, input bit en, input logic [31:0] exp_word,
                             input int exp_late, input string tag);
        int          b_fd, b_soc, b_late;
        logic [31:0] word;
        exp_t        e;
        adc_val[d] = val;
        eoc_en[d]  = en;
        b_fd   = n_fd[d];
        b_soc  = n_soc[d];
        b_late = n_late[d];
        exp_q.push_back('{d: d, word: exp_word, ch: ch, late: exp_late});
        spi_frame(d, ch, nbits, 1'b0, word);
        wait_clks(12);
        e = exp_q.pop_front();
        check_eq({tag, "_word"}, word, e.word);
        check_eq({tag, "_ch"}, 32'(ch_w[e.d]), 32'(e.ch));
        check_eq({tag, "_fd"}, 32'(n_fd[e.d] - b_fd), 32'd1);
        check_eq({tag, "_soc"}, 32'(n_soc[e.d] - b_soc), 32'd1);
        check_eq({tag, "_late"}, 32'(n_late[e.d] - b_late), 32'(e.late));
    endtask

    initial begin
        logic [31:0] word;
        int          b_fd, b_late;
        n_chk  = 0;
        n_fail = 0;
        xres   = 1'b1;
        ss_d   = '1;
        mosi_d = '0;
        for (int k = 0; k < c_NDUT; k++) begin
            sclk_d[k]    = (cpol_t[k] != 0);
            eoc_delay[k] = 3;
            eoc_en[k]    = 1'b1;
            adc_val[k]   = '0;
        end
        wait_clks(5);
        check_eq("reset_outs", {miso_w, oe_w, soc_w, fd_w, late_w, 7'd0}, 32'd0);
        check_eq("reset_ch", 32'(ch_w), 32'd0);
        xres = 1'b0;
        wait_clks(10);

        run_frame(0, 4'd5, 16'h0A5C, 16, 1'b1, 32'h0A5C, 0, "m0");
        run_frame(1, 4'd2, 16'h0123, 16, 1'b1, 32'h0123, 0, "m1");
        run_frame(2, 4'd2, 16'h0123, 16, 1'b1, 32'h0123, 0, "m2");
        run_frame(3, 4'd2, 16'h0123, 16, 1'b1, 32'h0123, 0, "m3");

        run_frame(0, 4'd6, 16'h0777, 16, 1'b0, 32'h0, 1, "late");

        // Abort after six sclk cycles
        eoc_en[0]  = 1'b1;
        adc_val[0] = 16'h0321;
        b_fd   = n_fd[0];
        b_late = n_late[0];
        spi_frame(0, 4'd4, 6, 1'b1, word);
        ss_d[0] = 1'b1;
        wait_clks(4);
        check_eq("abort_idle", 32'(g_m[0].u_dut.r_state), 32'(IDLE));
        wait_clks(20);
        check_eq("abort_fd", 32'(n_fd[0] - b_fd), 32'd0);
        check_eq("abort_late", 32'(n_late[0] - b_late), 32'd0);
        check_eq("abort_ch", 32'(ch_w[0]), 32'd4);
        run_frame(0, 4'd7, 16'h0FFF, 16, 1'b1, 32'h0FFF, 0, "post_abort");

        // Over-long window: bits beyond the frame read as zero
        run_frame(0, 4'd3, 16'h03C7, 20, 1'b1, 32'h03C70, 0, "long");

        // Reset in the middle of the wide build's data phase
        adc_val[4] = 16'hBEEF;
        eoc_en[4]  = 1'b1;
        spi_frame(4, 4'd9, 14, 1'b1, word);
        xres = 1'b1;
        @(posedge clk);
        #1;
        check_eq("xres_outs", {miso_w, oe_w, soc_w, fd_w, late_w, 7'd0}, 32'd0);
        check_eq("xres_ch", 32'(ch_w), 32'd0);
        ss_d[4] = 1'b1;
        wait_clks(4);
        xres = 1'b0;
        wait_clks(10);
        run_frame(4, 4'd5, 16'hA5C3, 24, 1'b1, 32'hA5C3, 0, "wide");

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
